cpu_mem_system: RTL and testbench
=================================

# cpu_mem_system

Minimal 16-bit accumulator CPU coupled to a 4096 x 16-bit single-port synchronous RAM, forming the complete system exercised at top level. The RAM is preloaded by backdoor write to its word array while reset is asserted. The CPU then fetches and executes from address 0 until it executes HALT, at which point it raises a sticky end-of-program flag.

## Interface
- ADDR_WIDTH, 12: word-address width, $clog2(MEM_DEPTH).
- MEM_DEPTH, 4096: RAM depth in 16-bit words.
- clk_i  in  1  system clock; all logic on rising edge.
- rst_i  in  1  reset; one clock; reset is asynchronous and active-low.
- end_program_o  out  1  high from the cycle HALT is decoded until reset.
- mem_addr_o  out  ADDR_WIDTH  observed CPU-to-RAM address.
- mem_enable_o  out  1  observed RAM enable.
- mem_rd_en_o  out  1  observed read strobe.
- mem_wr_en_o  out  1  observed write strobe.
- mem_value_o  out  16  observed write data (CPU to RAM).
- mem_value_i  out  16  observed read data (RAM to CPU; named as the CPU-side input).

## Operation
- RAM array `ram[0:MEM_DEPTH-1]` is 16-bit and word-addressed. Reset never clears it; backdoor preload is legal while rst_i=0.
- Instruction format: [15:12] opcode, [11:0] address or imm12.
- Registers: PC (12-bit), IR (16), A (16), flags Z and C. Reset values: PC=0, A=0, Z=0, C=0, IR=0.
- Opcodes:
  - 0 HALT.
  - 1 LOAD: A=M[a].
  - 2 STORE: M[a]=A.
  - 3 ADD: A=A+M[a], C=carry-out.
  - 4 SUB: A=A-M[a], C=borrow.
  - 5 AND.
  - 6 OR.
  - 7 XOR.
  - 8 LDI: A={4'b0,imm12}.
  - 9 JMP: PC=a.
  - A JZ: jump if Z.
  - B JC: jump if C.
  - C JN: jump if A[15].
  - D ADC: see Configuration.
  - E SHL: A=A<<1, C=old A[15].
  - F SHR: A=A>>1 logical, C=old A[0].
- Z is updated as (new A==0) by every opcode that writes A. C changes only where stated above.
- All arithmetic is modulo 2^16. PC increments modulo 2^12, so 4095 wraps to 0.
- FSM states: FETCH, DECODE, OPER, EXEC, WRITE, HALT.
  - FETCH: mem_addr_o=PC, enable=1, rd_en=1. Next state DECODE.
  - DECODE: IR=mem_value_i, PC=PC+1.
    - Opcodes 1,3-7,D go to OPER.
    - Opcode 2 goes to WRITE.
    - Opcode 0 goes to HALT.
    - Opcodes 8,9,A-C,E,F execute in DECODE and go to FETCH. A taken jump overrides the increment.
  - OPER: addr=IR[11:0], enable=1, rd_en=1. Next state EXEC.
  - EXEC: ALU result is written to A. Next state FETCH.
  - WRITE: addr=IR[11:0], enable=1, wr_en=1, mem_value_o=A. Next state FETCH.
  - HALT: absorbing; all strobes 0; end_program_o=1.
- DECODE uses the IR value combinationally from mem_value_i.
- In all other states, enable, rd_en and wr_en are 0 and mem_addr_o holds its last value.
- rd_en and wr_en are never high together.

## Timing
- RAM read: with enable & rd_en at edge N, dout = ram[addr] after edge N; it holds until the next read.
- RAM write: with enable & wr_en at edge N, ram[addr] = din at edge N. The write does not update dout.
- Latency per instruction:
  - 4 cycles for memory-operand ALU ops.
  - 3 cycles for STORE.
  - 2 cycles for LDI, jumps, shifts and illegal-free opcodes.
  - HALT enters the HALT state after 2 cycles.
- Reset assertion clears CPU state immediately. All outputs go to 0, except mem_value_i, which is RAM dout and is also cleared to 0.
- The first FETCH is at the first rising edge after rst_i rises. Reset asserted mid-instruction aborts that instruction; a pending write does not occur.
- end_program_o is registered: it is 1 in the first cycle the FSM is in HALT.

## Configuration
- CPU_ADC_EN defined: opcode D is ADC, A=A+M[a]+C, C=carry-out. This supports multi-word counters.
- CPU_ADC_EN undefined: opcode D is a 2-cycle NOP. It causes no operand read and no flag change.

## Test plan
- Reset: hold rst_i=0, preload ram; release. Require mem_addr_o=0 and rd_en=1 on the first cycle, and end_program_o=0.
- ram[0]=0x8005 (LDI 5), ram[1]=0x2100 (STORE 0x100), ram[2]=0x0000 -> ram[0x100]=0x0005, end_program_o=1 after 7 cycles.
- Carry: A=0xFFFF, ADD of M=0x0001 -> A=0x0000, Z=1, C=1. A following JC is taken.
- With CPU_ADC_EN: 32-bit counter from 0x0000FFFF incremented by 1 -> low word 0x0000, high word 0x0001. Without the macro, ADC leaves A unchanged.
- PC wrap: JMP 0xFFF with ram[0xFFF]=0x9000 -> next fetch at 0x000. HALT persists with no further memory strobes.
- Reset mid-WRITE: assert rst_i during the WRITE state -> target word is unchanged and outputs clear immediately.

Source files
------------

// File: rtl/cpu_mem_system.sv
`default_nettype none
// ============================================================================
// Module   : cpu_mem_system
// Purpose  : 16-bit accumulator CPU with a 4096x16 single-port synchronous RAM.
//            Optional macro CPU_ADC_EN turns opcode D into add-with-carry.
// Revision : 1.0
// ============================================================================
module cpu_mem_system #(
    parameter int MEM_DEPTH  = 4096,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic                  end_program_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_enable_o,
    output logic                  mem_rd_en_o,
    output logic                  mem_wr_en_o,
    output logic [15:0]           mem_value_o,
    output logic [15:0]           mem_value_i
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_OPER   = 3'd2,
        S_EXEC   = 3'd3,
        S_WRITE  = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_HALT  = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_XOR   = 4'h7;
    localparam logic [3:0] OP_LDI   = 4'h8;
    localparam logic [3:0] OP_JMP   = 4'h9;
    localparam logic [3:0] OP_JZ    = 4'hA;
    localparam logic [3:0] OP_JC    = 4'hB;
    localparam logic [3:0] OP_JN    = 4'hC;
    localparam logic [3:0] OP_ADC   = 4'hD;
    localparam logic [3:0] OP_SHL   = 4'hE;
    localparam logic [3:0] OP_SHR   = 4'hF;

    logic [15:0] ram [0:MEM_DEPTH-1];

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [15:0]             ir_q, ir_d;
    logic [15:0]             a_q, a_d;
    logic                    z_q, z_d;
    logic                    c_q, c_d;
    logic                    end_q, end_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [15:0]             rdata_q;

    logic                    w_en;
    logic                    w_rd;
    logic                    w_wr;
    logic                    w_a_wr;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [15:0]             w_wdata;
    logic [3:0]              w_dec_op;
    logic [ADDR_WIDTH-1:0]   w_dec_imm;

    // The instruction word is consumed straight off the RAM output in DECODE.
    assign w_dec_op  = mem_value_i[15:12];
    assign w_dec_imm = mem_value_i[ADDR_WIDTH-1:0];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        z_d     = z_q;
        c_d     = c_q;
        end_d   = end_q;
        w_en    = 1'b0;
        w_rd    = 1'b0;
        w_wr    = 1'b0;
        w_a_wr  = 1'b0;
        w_addr  = addr_q;
        w_wdata = '0;

        case (state_q)
            S_FETCH: begin
                w_addr  = pc_q;
                w_en    = 1'b1;
                w_rd    = 1'b1;
                state_d = S_DECODE;
            end

            S_DECODE: begin
                ir_d    = mem_value_i;
                pc_d    = pc_q + 1'b1;
                state_d = S_FETCH;
                case (w_dec_op)
                    OP_HALT: begin
                        state_d = S_HALT;
                        end_d   = 1'b1;
                    end
                    OP_STORE: state_d = S_WRITE;
                    OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:
                        state_d = S_OPER;
`ifdef CPU_ADC_EN
                    OP_ADC:   state_d = S_OPER;
`else
                    OP_ADC:   state_d = S_FETCH;
`endif
                    OP_LDI: begin
                        a_d    = {4'b0000, mem_value_i[11:0]};
                        w_a_wr = 1'b1;
                    end
                    OP_JMP:   pc_d = w_dec_imm;
                    OP_JZ:    if (z_q)    pc_d = w_dec_imm;
                    OP_JC:    if (c_q)    pc_d = w_dec_imm;
                    OP_JN:    if (a_q[15]) pc_d = w_dec_imm;
                    OP_SHL: begin
                        a_d    = {a_q[14:0], 1'b0};
                        c_d    = a_q[15];
                        w_a_wr = 1'b1;
                    end
                    OP_SHR: begin
                        a_d    = {1'b0, a_q[15:1]};
                        c_d    = a_q[0];
                        w_a_wr = 1'b1;
                    end
                    default: state_d = S_FETCH;
                endcase
            end

            S_OPER: begin
                w_addr  = ir_q[ADDR_WIDTH-1:0];
                w_en    = 1'b1;
                w_rd    = 1'b1;
                state_d = S_EXEC;
            end

            S_EXEC: begin
                state_d = S_FETCH;
                w_a_wr  = 1'b1;
                case (ir_q[15:12])
                    OP_LOAD: a_d = mem_value_i;
                    OP_ADD:  {c_d, a_d} = {1'b0, a_q} + {1'b0, mem_value_i};
                    // Bit 16 of the 17-bit difference is the borrow.
                    OP_SUB:  {c_d, a_d} = {1'b0, a_q} - {1'b0, mem_value_i};
                    OP_AND:  a_d = a_q & mem_value_i;
                    OP_OR:   a_d = a_q | mem_value_i;
                    OP_XOR:  a_d = a_q ^ mem_value_i;
`ifdef CPU_ADC_EN
                    OP_ADC:  {c_d, a_d} = {1'b0, a_q} + {1'b0, mem_value_i} + {16'b0, c_q};
`endif
                    default: w_a_wr = 1'b0;
                endcase
            end

            S_WRITE: begin
                w_addr  = ir_q[ADDR_WIDTH-1:0];
                w_en    = 1'b1;
                w_wr    = 1'b1;
                w_wdata = a_q;
                state_d = S_FETCH;
            end

            S_HALT: begin
                state_d = S_HALT;
                end_d   = 1'b1;
            end

            default: state_d = S_FETCH;
        endcase

        if (w_a_wr) begin
            z_d = (a_d == 16'h0000);
        end
    end

    // Strobes are masked while reset is held so the RAM cannot be touched
    // and the first FETCH becomes visible as soon as reset is released.
    assign mem_enable_o  = w_en & rst_i;
    assign mem_rd_en_o   = w_rd & rst_i;
    assign mem_wr_en_o   = w_wr & rst_i;
    assign mem_addr_o    = w_addr;
    assign mem_value_o   = w_wdata;
    assign mem_value_i   = rdata_q;
    assign end_program_o = end_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            a_q     <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            end_q   <= 1'b0;
            addr_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            z_q     <= z_d;
            c_q     <= c_d;
            end_q   <= end_d;
            addr_q  <= w_addr;
            if (mem_enable_o && mem_rd_en_o) begin
                rdata_q <= ram[mem_addr_o];
            end
        end
    end

    // Storage array is never reset so backdoor preload survives reset.
    always_ff @(posedge clk_i) begin
        if (mem_enable_o && mem_wr_en_o) begin
            ram[mem_addr_o] <= mem_value_o;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_mem_system.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_mem_system
// Purpose  : Scoreboard bench for cpu_mem_system; programs are backdoor loaded.
// Revision : 1.0
// ============================================================================
module tb_cpu_mem_system;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        end_program_o;
    logic [11:0] mem_addr_o;
    logic        mem_enable_o;
    logic        mem_rd_en_o;
    logic        mem_wr_en_o;
    logic [15:0] mem_value_o;
    logic [15:0] mem_value_i;

    typedef struct packed {
        logic [11:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t         sb[$];
    wr_t         mon_e;
    logic [15:0] prog_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk_i = ~clk_i;

    cpu_mem_system #(
        .MEM_DEPTH (4096),
        .ADDR_WIDTH(12)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .end_program_o (end_program_o),
        .mem_addr_o    (mem_addr_o),
        .mem_enable_o  (mem_enable_o),
        .mem_rd_en_o   (mem_rd_en_o),
        .mem_wr_en_o   (mem_wr_en_o),
        .mem_value_o   (mem_value_o),
        .mem_value_i   (mem_value_i)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe seen by the RAM must match the queue head.
    always @(negedge clk_i) begin
        if (rst_i && mem_enable_o && mem_wr_en_o) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                         mem_addr_o, mem_value_o);
            end else begin
                mon_e = sb.pop_front();
                check("write_addr_data", {4'h0, mem_addr_o, mem_value_o},
                      {4'h0, mon_e.addr, mon_e.data});
                check("write_rd_excl", {31'd0, mem_rd_en_o}, 32'd0);
            end
        end
    end

    task automatic expect_wr(input logic [11:0] a, input logic [15:0] d);
        sb.push_back(wr_t'{a, d});
    endtask

    // Called while reset is held: wipe RAM and place prog_q at address 0.
    task automatic load_prog();
        for (int i = 0; i < 4096; i++) dut.ram[i] = 16'h0000;
        for (int i = 0; i < prog_q.size(); i++) dut.ram[i] = prog_q[i];
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_addr"},   {20'd0, mem_addr_o}, 32'd0);
        check({name, "_strobe"}, {29'd0, mem_enable_o, mem_rd_en_o, mem_wr_en_o}, 32'd0);
        check({name, "_wdata"},  {16'd0, mem_value_o}, 32'd0);
        check({name, "_rdata"},  {16'd0, mem_value_i}, 32'd0);
        check({name, "_end"},    {31'd0, end_program_o}, 32'd0);
    endtask

    task automatic assert_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
    endtask

    task automatic run_to_halt(input string name, input int exp_cycles);
        int cyc;
        cyc = 0;
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check({name, "_fetch0"}, {19'd0, mem_addr_o, mem_rd_en_o}, {19'd0, 12'h000, 1'b1});
        while (cyc < 2000) begin
            @(posedge clk_i);
            cyc++;
            #1;
            if (end_program_o) break;
        end
        check({name, "_cycles"}, cyc, exp_cycles);
        check({name, "_sb_drained"}, sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        int cyc;
        int strobes;
        logic found;

        repeat (2) @(negedge clk_i);
        check_reset_outputs("reset_initial");

        // LDI 5 / STORE 0x100 / HALT
        prog_q = '{16'h8005, 16'h2100, 16'h0000};
        load_prog();
        expect_wr(12'h100, 16'h0005);
        run_to_halt("ldi_store", 7);
        check("ldi_store_ram", {16'd0, dut.ram[12'h100]}, 32'h0005);
        check("ldi_store_end", {31'd0, end_program_o}, 32'd1);

        // Reset from HALT must clear every output at once.
        assert_reset();
        check_reset_outputs("reset_from_halt");

        // Carry: 0xFFFF + 1 -> 0, C=1; JC must skip the 0xBAD store.
        prog_q = '{16'h1010, 16'h3011, 16'h2100, 16'hB006, 16'h8BAD,
                   16'h2101, 16'h8123, 16'h2102, 16'h0000};
        load_prog();
        dut.ram[12'h010] = 16'hFFFF;
        dut.ram[12'h011] = 16'h0001;
        expect_wr(12'h100, 16'h0000);
        expect_wr(12'h102, 16'h0123);
        run_to_halt("carry", 20);
        check("carry_skip", {16'd0, dut.ram[12'h101]}, 32'd0);
        check("carry_taken", {16'd0, dut.ram[12'h102]}, 32'h0123);

        // 32-bit increment of 0x0007_FFFF through opcode D.
        assert_reset();
        prog_q = '{16'h1020, 16'h3022, 16'h2020, 16'h1021, 16'hD023, 16'h2021, 16'h0000};
        load_prog();
        dut.ram[12'h020] = 16'hFFFF;
        dut.ram[12'h021] = 16'h0007;
        dut.ram[12'h022] = 16'h0001;
        dut.ram[12'h023] = 16'h0000;
        expect_wr(12'h020, 16'h0000);
`ifdef CPU_ADC_EN
        expect_wr(12'h021, 16'h0008);
        run_to_halt("adc", 24);
        check("adc_hi", {16'd0, dut.ram[12'h021]}, 32'h0008);
`else
        expect_wr(12'h021, 16'h0007);
        run_to_halt("adc_nop", 22);
        check("adc_nop_hi", {16'd0, dut.ram[12'h021]}, 32'h0007);
`endif
        check("adc_lo", {16'd0, dut.ram[12'h020]}, 32'h0000);

        // ALU mix: AND/OR/XOR/SUB/SHL/SHR, JN and JC taken.
        assert_reset();
        prog_q = '{16'h80FF, 16'h5031, 16'h2110, 16'h6030, 16'h7031, 16'h2111,
                   16'h4032, 16'hE000, 16'h2112, 16'h8000, 16'h4032, 16'hC00D,
                   16'h0000, 16'hF000, 16'h2113, 16'hB011, 16'h0000, 16'hF000,
                   16'h2114, 16'h0000};
        load_prog();
        dut.ram[12'h030] = 16'h00F0;
        dut.ram[12'h031] = 16'h0F0F;
        dut.ram[12'h032] = 16'h0001;
        expect_wr(12'h110, 16'h000F);
        expect_wr(12'h111, 16'h0FF0);
        expect_wr(12'h112, 16'h1FDE);
        expect_wr(12'h113, 16'h7FFF);
        expect_wr(12'h114, 16'h3FFF);
        run_to_halt("alu_mix", 51);

        // PC wrap: instruction at 0xFFF falls through to 0x000.
        assert_reset();
        prog_q = '{16'hA005, 16'h9FFF, 16'h0000, 16'h0000, 16'h0000,
                   16'h80AB, 16'h2200, 16'h0000};
        load_prog();
        dut.ram[12'hFFF] = 16'h8000;
        expect_wr(12'h200, 16'h00AB);
        run_to_halt("pc_wrap", 15);
        strobes = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (mem_enable_o || mem_rd_en_o || mem_wr_en_o) strobes++;
        end
        check("halt_no_strobes", strobes, 0);
        check("halt_sticky", {31'd0, end_program_o}, 32'd1);

        // Reset asserted during WRITE must abort the store.
        assert_reset();
        prog_q = '{16'h8055, 16'h2300, 16'h0000};
        load_prog();
        dut.ram[12'h300] = 16'h1234;
        @(negedge clk_i);
        rst_i = 1'b1;
        cyc   = 0;
        found = 1'b0;
        while (cyc < 50 && !found) begin
            @(posedge clk_i);
            cyc++;
            #1;
            found = mem_wr_en_o;
        end
        check("abort_write_cycle", cyc, 4);
        rst_i = 1'b0;
        #1;
        check_reset_outputs("abort_outputs");
        repeat (2) @(posedge clk_i);
        #1;
        check("abort_ram_kept", {16'd0, dut.ram[12'h300]}, 32'h1234);
        sb.delete();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
